// File: rtl/uart_pkg.sv
// Shared UART constants, frame state encoding and small helpers.
package uart_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned BAUD        = 9600;
  // One 10-bit character (start + 8 data + stop) in system clock cycles.
  localparam int unsigned BYTE_CYCLES = CLK_HZ * 10 / BAUD;

  localparam logic [7:0] HEADER_BYTE  = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ARG  = 3'd2,
    ST_CHK  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_controller_if.sv
// Command handshake between the frame controller and the system core.
interface uart_cmd_controller_if;

  logic [7:0] cmd;
  logic [7:0] arg;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd, output arg, output cmd_valid, input cmd_ready);
  modport slave  (input cmd, input arg, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/uart_cmd_controller_pulse_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module pulse_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic byte_stb
);

  logic sync1;
  logic sync2;
  logic prev;

  // Resynchronise the level and emit a one-cycle strobe on its rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      byte_stb <= 1'b0;
    end else begin
      sync1    <= level;
      sync2    <= sync1;
      prev     <= sync2;
      byte_stb <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/uart_cmd_controller.sv
// Assembles header/cmd/arg/checksum frames from the byte receiver, presents
// validated commands over a valid/ready handshake, and supervises the
// receiver with an inter-byte timeout and a saturating error counter.
module uart_cmd_controller
  import uart_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 2 * BYTE_CYCLES,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_received,
  output logic                         rx_rst,
  uart_cmd_controller_if.master        cmd_bus,
  output logic                         busy,
  output logic [7:0]                   err_count
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [7:0]       cmd_q;
  logic [7:0]       cmd_next;
  logic [7:0]       arg_q;
  logic [7:0]       arg_next;
  logic             err;
  logic             byte_stb;
  logic             timeout;

  pulse_sync u_rx_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .level    (rx_received),
    .byte_stb (byte_stb)
  );

  assign timeout = (timer == CNT_W'(TIMEOUT_CYCLES - 1));

  // Frame sequencing: next state, timer, captured fields and error flag.
  // A byte strobe always takes priority over an expiring timer.
  always_comb begin
    state_next = state;
    timer_next = timer;
    cmd_next   = cmd_q;
    arg_next   = arg_q;
    err        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (byte_stb) begin
          timer_next = '0;
          if (rx_data == HEADER) state_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (byte_stb) begin
          cmd_next   = rx_data;
          timer_next = '0;
          state_next = ST_ARG;
        end else if (timeout) begin
          err        = 1'b1;
          timer_next = '0;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_ARG: begin
        if (byte_stb) begin
          arg_next   = rx_data;
          timer_next = '0;
          state_next = ST_CHK;
        end else if (timeout) begin
          err        = 1'b1;
          timer_next = '0;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_CHK: begin
        if (byte_stb) begin
          timer_next = '0;
          if (rx_data == (cmd_q ^ arg_q)) begin
            state_next = ST_HOLD;
          end else begin
            err        = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (timeout) begin
          err        = 1'b1;
          timer_next = '0;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_HOLD: begin
        // A byte here is an overrun: dropped, but the held frame survives.
        if (byte_stb) err = 1'b1;
        if (cmd_bus.cmd_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // State, timer, frame fields, receiver reset pulse and error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      cmd_q     <= '0;
      arg_q     <= '0;
      rx_rst    <= 1'b1;
      err_count <= '0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      cmd_q     <= cmd_next;
      arg_q     <= arg_next;
      rx_rst    <= err;
      if (err) err_count <= sat_inc8(err_count);
    end
  end

  assign cmd_bus.cmd       = cmd_q;
  assign cmd_bus.arg       = arg_q;
  assign cmd_bus.cmd_valid = (state == ST_HOLD);
  assign busy              = (state != ST_IDLE);

endmodule

// File: doc/uart_cmd_controller.md
# uart_cmd_controller

Sequencer between the 9600-baud byte receiver and the system core. It watches the receiver's `data_received` strobe and `data` byte, resynchronises them into the system clock domain, and assembles 4-byte command frames (header, command, argument, checksum). It presents validated commands to the core over a valid/ready handshake. It also supervises the receiver: on an inter-byte timeout or a bad frame, it pulses the receiver's reset and counts the error.

## Interface

Parameters:
- `HEADER`, 8'hAA: frame start byte.
- `TIMEOUT_CYCLES`, 104_166: clk cycles allowed between bytes inside a frame (2 byte-times at 50 MHz).
- `CNT_W`, 17: timeout counter width; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: byte from the receiver. It is stable while `rx_received` is high.
- `rx_received`, in, 1: receiver strobe from the 9600 Hz domain. It is asynchronous to `clk`.
- `rx_rst`, out, 1: active-high reset pulse to the receiver.
- `cmd`, out, 8: command byte of the accepted frame.
- `arg`, out, 8: argument byte of the accepted frame.
- `cmd_valid`, out, 1: `cmd`/`arg` hold a valid frame.
- `cmd_ready`, in, 1: core accepts the frame.
- `busy`, out, 1: a frame is in progress (any state other than IDLE).
- `err_count`, out, 8: saturating count of rejected frames.

## Operation

- Reset values: `rx_rst`=1 while `reset_n`=0, and `rx_rst` deasserts on the first `clk` edge after reset release. `cmd`=0, `arg`=0, `cmd_valid`=0, `busy`=0, `err_count`=0, state IDLE, timer 0.
- Input capture: `rx_received` passes through a 2-flop synchroniser and then a rising-edge detector. On the detected edge (`byte_stb`), `rx_data` is sampled directly; it is stable for a full baud period, so no synchroniser is needed on the data path.
- State machine:
  - IDLE: on `byte_stb`, go to CMD if the byte equals `HEADER`; otherwise ignore it. No error and no counting.
  - CMD: on `byte_stb`, latch `cmd`, go to ARG.
  - ARG: on `byte_stb`, latch `arg`, go to CHK.
  - CHK: on `byte_stb`, go to HOLD if the byte equals `cmd ^ arg`. Otherwise it is an error: pulse `rx_rst`, increment `err_count`, go to IDLE.
  - HOLD: `cmd_valid`=1. When `cmd_ready`=1, go to IDLE; `cmd_valid` drops the following cycle.
- Timeout:
  - The timer clears on every `byte_stb` and on entry to CMD.
  - It increments each cycle in CMD, ARG and CHK.
  - Reaching `TIMEOUT_CYCLES`-1 without a byte is an error: pulse `rx_rst`, increment `err_count`, go to IDLE.
  - The timer does not run in IDLE or HOLD.
- Overrun: a `byte_stb` in HOLD discards the byte, increments `err_count` and pulses `rx_rst`. The held frame is kept, `cmd_valid` stays 1, and the state is unchanged.
- `err_count` saturates at 8'hFF and never wraps.
- `cmd` and `arg` keep their last values outside HOLD and are only meaningful while `cmd_valid`=1.

## Timing

- Latency from an `rx_received` rising edge to `byte_stb`: 3 clk (2 synchroniser flops plus 1 edge register).
- After the checksum byte's `byte_stb`, `cmd_valid` rises on the next edge.
- Handshake:
  - A transfer happens when `cmd_valid` and `cmd_ready` are both 1 on the same edge.
  - `cmd_ready` may be held high permanently, giving a 1-cycle `cmd_valid` pulse per frame.
  - `cmd_valid` never drops without a transfer, except on reset.
- `rx_rst` is a single-cycle registered pulse, asserted the cycle after the error is detected.
- Simultaneous events:
  - `byte_stb` in the same cycle the timer expires: the byte wins. It is processed and the timer clears; no timeout is flagged.
  - Error and overrun in the same cycle cannot occur, because they come from different states.
- Reset mid-frame: the state returns to IDLE at once, and any partial or held frame is lost.
- Back-to-back frames: a header arriving in the cycle HOLD exits to IDLE is seen one cycle late and is therefore dropped as an overrun. The core must accept within one byte-time (about 52k cycles) to avoid this.

## Structure

- Shared package `uart_pkg`:
  - state encoding constants `ST_IDLE`, `ST_CMD`, `ST_ARG`, `ST_CHK`, `ST_HOLD` (3 bits);
  - default `HEADER`;
  - baud-derived constants `CLK_HZ` and `BYTE_CYCLES`.
- Sub-module `pulse_sync`: a 2-flop synchroniser plus rising-edge detector with an active-low async reset, outputting `byte_stb`. It is reused by the future transmitter controller.
- Everything else (frame state machine, timeout counter, error counter) stays in `uart_cmd_controller`.

## Test plan

- Good frame: bytes AA 12 34 26 with `cmd_ready`=1. Expect `cmd`=12, `arg`=34, `cmd_valid` high for 1 cycle, `err_count`=0, and no `rx_rst`.
- Bad checksum: AA 12 34 27. Expect no `cmd_valid`, one `rx_rst` pulse, `err_count`=1, and the state back in IDLE. A following good frame AA 01 02 03 is then accepted.
- Timeout: AA 12, then no byte for `TIMEOUT_CYCLES`. Expect `rx_rst` pulse, `err_count`+1, and `busy`=0. Then 34 26 alone produces no `cmd_valid`.
- Backpressure and overrun: frame AA 05 06 03 with `cmd_ready`=0, then byte 77. Expect `cmd_valid` held with `cmd`=05 and `arg`=06, `err_count`+1, and the frame intact. Raising `cmd_ready` transfers 05/06.
- Saturation and reset: 260 bad frames give `err_count`=FF. Asserting `reset_n`=0 mid-frame clears all outputs and holds `rx_rst`=1 until release.
- Idle garbage: bytes 00 55 FF in IDLE produce no state change, no error and no `rx_rst`.
